// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the CPU-side memory bus responder.
package mem_bus_pkg;

  localparam int unsigned WordBits    = 16;
  localparam int unsigned ByteBits    = 8;
  localparam int unsigned CpuAddrBits = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StResp
  } state_e;

endpackage

// File: rtl/byte_ram.sv
// Single-port byte-wide RAM with synchronous read and write and no reset.
// INIT_ZERO selects a zero-filled power-up image.
module byte_ram
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 14,
  parameter bit          INIT_ZERO = 1'b0
) (
  input  logic                 clock,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [ByteBits-1:0]  wdata,
  output logic [ByteBits-1:0]  rdata
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  if (INIT_ZERO) begin : g_init_zero
    logic [ByteBits-1:0] mem [Depth] = '{default: 8'h00};

    always_ff @(posedge clock) begin
      if (en) begin
        if (we) mem[addr] <= wdata;
        else    rdata     <= mem[addr];
      end
    end
  end else begin : g_no_init
    logic [ByteBits-1:0] mem [Depth];

    always_ff @(posedge clock) begin
      if (en) begin
        if (we) mem[addr] <= wdata;
        else    rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Word-wide request/response responder over a byte RAM, two byte cycles per word.
// Define MEM_BUS_RESPONDER_ALIGN_CHECK_EN to reject odd word addresses.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 14,
  parameter bit          INIT_ZERO = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [CpuAddrBits-1:0] req_addr,
  input  logic [WordBits-1:0]    req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WordBits-1:0]    resp_rdata,
  output logic                   resp_error
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  state_e                 state_q;
  logic                   write_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [WordBits-1:0]    wdata_q;
  logic [ByteBits-1:0]    lo_q;
  logic                   rd_valid_q;
  logic                   resp_error_q;

  logic                   req_err;
  logic                   ram_en;
  logic                   ram_we;
  logic [ADDR_BITS-1:0]   ram_addr;
  logic [ByteBits-1:0]    ram_wdata;
  logic [ByteBits-1:0]    ram_rdata;

  // Out of range, or the last byte where A+1 would fall off the end.
  always_comb begin
    req_err = ((32'(req_addr) >> ADDR_BITS) != 32'd0) || (32'(req_addr) == Depth - 1);
`ifdef MEM_BUS_RESPONDER_ALIGN_CHECK_EN
    if (req_addr[0]) req_err = 1'b1;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      rd_valid_q   <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr[ADDR_BITS-1:0];
            wdata_q <= req_wdata;
            if (req_err) begin
              resp_error_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              state_q <= StLo;
            end
          end
        end
        StLo: state_q <= StHi;
        StHi: begin
          // RAM output currently holds byte A; byte A+1 lands there at this edge.
          lo_q       <= ram_rdata;
          rd_valid_q <= !write_q;
          state_q    <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            rd_valid_q   <= 1'b0;
            resp_error_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ram_en    = (state_q == StLo) || (state_q == StHi);
    ram_we    = write_q;
    ram_addr  = (state_q == StHi) ? addr_q + ADDR_BITS'(1) : addr_q;
    ram_wdata = (state_q == StHi) ? wdata_q[15:8] : wdata_q[7:0];
  end

  // RAM is idle in RESP, so its output register holds byte A+1 stable.
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_error = resp_error_q;
  assign resp_rdata = rd_valid_q ? {ram_rdata, lo_q} : '0;

  byte_ram #(
    .ADDR_BITS(ADDR_BITS),
    .INIT_ZERO(INIT_ZERO)
  ) u_byte_ram (
    .clock(clock),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder (ADDR_BITS = 14).
module tb_mem_bus_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_rdata;
  logic        resp_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model[int];

  mem_bus_responder #(
    .ADDR_BITS(14),
    .INIT_ZERO(1'b0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );

  always #5 clock = ~clock;

  function automatic logic addr_err(input logic [15:0] a);
    logic e;
    e = (a >= 16'h4000) || (a == 16'h3FFF);
`ifdef MEM_BUS_RESPONDER_ALIGN_CHECK_EN
    if (a[0]) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [7:0] model_rd(input int a);
    if (model.exists(a)) return model[a];
    return 8'h00;
  endfunction

  // Issue one request from IDLE; push the expected response; wait for resp_valid.
  // lat counts cycles from the accept cycle (1 = the cycle right after the accept edge).
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                       output int lat);
    exp_t e;
    e.err   = addr_err(addr);
    e.rdata = (wr || e.err) ? 16'h0000 : {model_rd(int'(addr) + 1), model_rd(int'(addr))};
    if (wr && !e.err) begin
      model[int'(addr)]     = wd[7:0];
      model[int'(addr) + 1] = wd[15:8];
    end
    exp_q.push_back(e);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 12) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  // Pop the scoreboard against the current response, then accept it.
  task automatic drain(input string name);
    exp_t e;
    checks++;
    if (resp_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s timeout: resp_valid=%b queued=%0d required resp_valid=1",
               name, resp_valid, exp_q.size());
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (resp_rdata !== e.rdata || resp_error !== e.err) begin
        errors++;
        $display("FAIL %s resp: rdata=%h error=%b required rdata=%h error=%b",
                 name, resp_rdata, resp_error, e.rdata, e.err);
      end
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 16'h0000 || resp_error !== 1'b0 ||
        req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s exit: valid=%b rdata=%h error=%b ready=%b required 0 0000 0 1",
               name, resp_valid, resp_rdata, resp_error, req_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b error=%b rdata=%h required 0 0 0000",
               resp_valid, resp_error, resp_rdata);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    int lat;
    issue(1'b1, 16'h0010, 16'hBEEF, lat);
    drain("write_beef");
    issue(1'b0, 16'h0010, 16'h0000, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL read_latency: got %0d cycles required 3", lat);
    end
    checks++;
    if (resp_rdata[7:0] !== 8'hEF || resp_rdata[15:8] !== 8'hBE) begin
      errors++;
      $display("FAIL byte_order: lo=%h hi=%h required lo=ef hi=be",
               resp_rdata[7:0], resp_rdata[15:8]);
    end
    drain("read_beef");
  endtask

  task automatic test_errors();
    int lat;
    issue(1'b0, 16'h4000, 16'h0000, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL err_latency_4000: got %0d cycles required 1", lat);
    end
    drain("read_4000");
    issue(1'b0, 16'h3FFF, 16'h0000, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL err_latency_3fff: got %0d cycles required 1", lat);
    end
    drain("read_3fff");
    // Would alias onto 0x0010 if the high address bits were dropped.
    issue(1'b1, 16'h4010, 16'h1111, lat);
    drain("write_4010");
    issue(1'b0, 16'h0010, 16'h0000, lat);
    drain("read_after_err");
    // Highest legal word.
    issue(1'b1, 16'h3FFE, 16'hC3A5, lat);
    drain("write_3ffe");
    issue(1'b0, 16'h3FFE, 16'h0000, lat);
    drain("read_3ffe");
  endtask

  task automatic test_hold();
    int          lat;
    logic [15:0] first;
    issue(1'b0, 16'h0010, 16'h0000, lat);
    first = resp_rdata;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0010;
      req_wdata = 16'h0000;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== first || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b rdata=%h ready=%b required 1 %h 0",
                 i, resp_valid, resp_rdata, req_ready, first);
      end
    end
    drain("hold_read");
    issue(1'b0, 16'h0010, 16'h0000, lat);
    drain("after_hold");
  endtask

  task automatic test_reset_mid_write();
    int lat;
    issue(1'b1, 16'h0020, 16'hFFFF, lat);
    drain("write_ffff");
    req_write = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'h1234;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 16'h0000 ||
        req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_hi: valid=%b error=%b rdata=%h ready=%b required 0 0 0000 1",
               resp_valid, resp_error, resp_rdata, req_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model[32'h20] = 8'h34;
    issue(1'b0, 16'h0020, 16'h0000, lat);
    drain("read_ff34");
  endtask

  task automatic test_align();
    int lat;
    issue(1'b1, 16'h0021, 16'hA55A, lat);
    drain("write_0021");
    issue(1'b0, 16'h0021, 16'h0000, lat);
    drain("read_0021");
    issue(1'b0, 16'h0020, 16'h0000, lat);
    drain("read_0020");
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(1'b1, 16'h0100, 16'h0F0F, lat);
    drain("b2b_w0");
    issue(1'b1, 16'h0102, 16'h7E81, lat);
    drain("b2b_w1");
    issue(1'b0, 16'h0100, 16'h0000, lat);
    drain("b2b_r0");
    issue(1'b0, 16'h0102, 16'h0000, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles required 3", lat);
    end
    drain("b2b_r1");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_hold();
    test_reset_mid_write();
    test_align();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
